uart_rx_core: RTL and testbench

//  - UART receive stage of the UART design. Takes the raw asynchronous RX pin

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// bit-level helper functions used by the receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE      = 16;
  localparam int SAMPLE_MID      = 8;
  localparam int CLK_DIV_DEFAULT = 65;

  // Majority vote of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even-parity check: 1 when the vector (data plus parity bit) has an even number of ones.
  function automatic logic even_parity_ok(input logic [16:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw RX pin plus a history flop for
// falling-edge detection. All flops reset to the idle-high line level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronize the asynchronous pin and keep one cycle of history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled deframer with a valid/ready holding register
// and one-cycle framing/overrun pulses. Optional even parity is enabled by
// defining UART_RX_PARITY_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 parity_err_o,
  output logic                 busy_o
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [15:0]    DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [3:0]     SAMP_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]     SAMP_A    = 4'(SAMPLE_MID - 1);
  localparam logic [3:0]     SAMP_B    = 4'(SAMPLE_MID);
  localparam logic [3:0]     SAMP_C    = 4'(SAMPLE_MID + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_e ST_AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e ST_AFTER_DATA = ST_STOP;
`endif

  logic rx_s;
  logic fall_s;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rx_i),
    .rx_s_o (rx_s),
    .fall_o (fall_s)
  );

  uart_state_e          state_q, state_d;
  logic [15:0]          div_q, div_d;
  logic [3:0]           samp_q, samp_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s7_q, s7_d, s8_q, s8_d, s9_q, s9_d;
  logic                 pend_q, pend_d;
  logic [DATA_BITS-1:0] pend_data_q, pend_data_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 par_ok_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  logic tick_s, end_s, stop_s, maj_end_s, maj_stop_s;

  assign tick_s     = (state_q != ST_IDLE) && (div_q == DIV_LAST);
  assign end_s      = tick_s && (samp_q == SAMP_LAST);
  assign stop_s     = tick_s && (samp_q == SAMP_C);
  assign maj_end_s  = maj3(s7_q, s8_q, s9_q);
  assign maj_stop_s = maj3(s7_q, s8_q, rx_s);

`ifdef UART_RX_PARITY_EN
  assign par_ok_s = even_parity_ok(17'({shift_q, par_q}));
`else
  assign par_ok_s = 1'b1;
`endif

  // Next-state logic: oversample timing, frame FSM and holding register.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    s7_d        = s7_q;
    s8_d        = s8_q;
    s9_d        = s9_q;
    pend_d      = 1'b0;
    pend_data_d = pend_data_q;
    data_d      = data_q;
    valid_d     = valid_q;
    ferr_d      = 1'b0;
    ovr_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
    perr_d      = 1'b0;
`endif

    // Tick counters are parked at zero in IDLE so ticks align to the start edge.
    if (state_q == ST_IDLE) begin
      div_d  = 16'd0;
      samp_d = 4'd0;
    end else if (tick_s) begin
      div_d  = 16'd0;
      samp_d = samp_q + 4'd1;
    end else begin
      div_d  = div_q + 16'd1;
      samp_d = samp_q;
    end

    if (tick_s && (samp_q == SAMP_A)) s7_d = rx_s; else s7_d = s7_q;
    if (tick_s && (samp_q == SAMP_B)) s8_d = rx_s; else s8_d = s8_q;
    if (tick_s && (samp_q == SAMP_C)) s9_d = rx_s; else s9_d = s9_q;

    case (state_q)
      ST_IDLE: begin
        bit_d = '0;
        if (fall_s) state_d = ST_START; else state_d = ST_IDLE;
      end
      ST_START: begin
        if (end_s) begin
          if (maj_end_s) state_d = ST_IDLE; else state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (end_s) begin
          shift_d = {maj_end_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_ONE;
          if (bit_q == BIT_LAST) state_d = ST_AFTER_DATA; else state_d = ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (end_s) begin
          par_d   = maj_end_s;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        // Decide mid stop bit so a back-to-back start edge is not missed.
        if (stop_s) begin
          state_d     = ST_IDLE;
          ferr_d      = ~maj_stop_s;
          pend_d      = maj_stop_s & par_ok_s;
          pend_data_d = shift_q;
`ifdef UART_RX_PARITY_EN
          perr_d      = ~par_ok_s;
`endif
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);

    if (valid_q && rx_ready_i) valid_d = 1'b0; else valid_d = valid_q;

    // A completed byte loads only if the holding register is free this cycle.
    if (pend_q) begin
      if (!valid_q || rx_ready_i) begin
        valid_d = 1'b1;
        data_d  = pend_data_q;
        ovr_d   = 1'b0;
      end else begin
        data_d  = data_q;
        ovr_d   = 1'b1;
      end
    end else begin
      data_d = data_q;
      ovr_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= 16'd0;
      samp_q      <= 4'd0;
      bit_q       <= '0;
      shift_q     <= '0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      s9_q        <= 1'b1;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      s9_q        <= s9_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q       <= par_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core (CLK_DIV=4, one bit = 64 clk).
// A behavioural model predicts delivered bytes and error pulse counts from
// the frames the bench sends; a negedge monitor records what the DUT does.
module tb_uart_rx_core;

  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i;
  logic       rx_ready_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;
  logic       busy_o;

  int n_cmp = 0;
  int n_mis = 0;

  // Observed activity.
  logic [7:0] got_q[$];
  int n_ferr = 0, n_ovr = 0, n_perr = 0, n_valid_cyc = 0, n_unstable = 0;
  logic       pv = 1'b0;
  logic       phs = 1'b0;
  logic [7:0] pd = 8'h00;

  // Model expectations.
  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  bit         m_full = 1'b0;
  logic [7:0] m_byte = 8'h00;

  always #5 clk = ~clk;

  uart_rx_core #(.CLK_DIV(CLK_DIV), .DATA_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o),
    .busy_o       (busy_o)
  );

  // Record handshakes, pulse cycles and data changes while valid is held.
  always @(negedge clk) begin
    if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
    if (frame_err_o)  n_ferr      <= n_ferr + 1;
    if (overrun_o)    n_ovr       <= n_ovr + 1;
    if (parity_err_o) n_perr      <= n_perr + 1;
    if (rx_valid_o)   n_valid_cyc <= n_valid_cyc + 1;
    if (pv && !phs && rx_valid_o && (rx_data_o != pd)) n_unstable <= n_unstable + 1;
    pv  <= rx_valid_o;
    pd  <= rx_data_o;
    phs <= rx_valid_o && rx_ready_i;
  end

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    tick(BIT_CLKS);
  endtask

  // Frame-level rules: stop=0 -> framing error; bad parity -> parity error;
  // a good byte is consumed, held, or overruns a full holding register.
  task automatic model_frame(input logic [7:0] d, input logic stop_b, input logic par_bad);
    logic par_ok;
    par_ok = !(PARITY_ON && par_bad);
    if (!stop_b) exp_ferr++;
    if (!par_ok) exp_perr++;
    if (stop_b && par_ok) begin
      if (m_full)          exp_ovr++;
      else if (rx_ready_i) exp_q.push_back(d);
      else begin
        m_full = 1'b1;
        m_byte = d;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_bad);
    model_frame(d, stop_b, par_bad);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PARITY_ON) drive_bit((^d) ^ par_bad);
    drive_bit(stop_b);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, int'(got_q.pop_front()), int'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    check({tag, "_ferr"}, n_ferr, exp_ferr);
    check({tag, "_ovr"}, n_ovr, exp_ovr);
    check({tag, "_perr"}, n_perr, exp_perr);
    check({tag, "_stable"}, n_unstable, 0);
  endtask

  initial begin
    int k;
    int v0;
    logic [7:0] rd;
    logic [7:0] b99;
    rst = 1'b1;
    rx_i = 1'b1;
    rx_ready_i = 1'b1;
    tick(3);
    check("rst_valid", rx_valid_o, 0);
    check("rst_data", rx_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_pulses", {frame_err_o, overrun_o, parity_err_o}, 0);
    rst = 1'b0;
    tick(20);

    // 1: single 0x55 frame, consumer ready.
    v0 = n_valid_cyc;
    send_frame(8'h55, 1'b1, 1'b0);
    tick(4);
    check_all("t1");
    check("t1_valid_cycles", n_valid_cyc - v0, 1);

    // 2: 20-clk low glitch is a false start.
    rx_i = 1'b0;
    tick(20);
    rx_i = 1'b1;
    check("t2_busy_rise", busy_o, 1);
    k = 0;
    while (busy_o && k < 100) begin
      tick(1);
      k++;
    end
    check("t2_busy_fall", busy_o, 0);
    check("t2_return_time", int'(k <= 48), 1);
    tick(40);
    check_all("t2");

    // 3: stop bit 0 -> framing error, then a good 0x3C.
    send_frame(8'hA3, 1'b0, 1'b0);
    rx_i = 1'b1;
    tick(32);
    check("t3_valid", rx_valid_o, 0);
    check_all("t3a");
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(4);
    check_all("t3b");

    // 4: consumer stalled across two back-to-back frames -> overrun.
    rx_ready_i = 1'b0;
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    rx_i = 1'b1;
    tick(4);
    check("t4_valid", rx_valid_o, 1);
    check("t4_data", rx_data_o, 8'h12);
    check_all("t4a");
    rx_ready_i = 1'b1;
    if (m_full) exp_q.push_back(m_byte);
    m_full = 1'b0;
    tick(1);
    check("t4_valid_drop", rx_valid_o, 0);
    tick(2);
    check_all("t4b");

    // 5: four back-to-back frames with ready held high.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    tick(4);
    check_all("t5");

`ifdef UART_RX_PARITY_EN
    // Parity: bad parity alone, then bad parity together with a bad stop bit.
    send_frame(8'h07, 1'b1, 1'b1);
    tick(4);
    check_all("tp_a");
    send_frame(8'hC5, 1'b0, 1'b1);
    rx_i = 1'b1;
    tick(32);
    check_all("tp_b");
`endif

    // Randomized frames against the model.
    for (int it = 0; it < 16; it++) begin
      rd = 8'($urandom);
      send_frame(rd, ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) == 0));
      rx_i = 1'b1;
      tick($urandom_range(8, 40));
      check_all("rnd");
    end

    // 6: reset mid-DATA with a full holding register.
    rx_ready_i = 1'b0;
    rd = 8'($urandom);
    send_frame(rd, 1'b1, 1'b0);
    rx_i = 1'b1;
    tick(8);
    check("t6_full", rx_valid_o, 1);
    b99 = 8'h99;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b99[i]);
    rx_i = b99[3];
    tick(BIT_CLKS / 2);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", rx_valid_o, 0);
    check("t6_rst_data", rx_data_o, 0);
    check("t6_rst_busy", busy_o, 0);
    m_full = 1'b0;
    tick(BIT_CLKS / 2);
    for (int i = 4; i < 7; i++) drive_bit(b99[i]);
    rx_i = b99[7];
    tick(BIT_CLKS / 2);
    rst = 1'b0;
    rx_ready_i = 1'b1;
    tick(BIT_CLKS / 2);
    drive_bit(1'b1);
    tick(200);
    check("t6_tail_busy", busy_o, 0);
    check("t6_tail_valid", rx_valid_o, 0);
    check_all("t6a");
    send_frame(8'h42, 1'b1, 1'b0);
    tick(4);
    check_all("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
